// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one pipelined double-precision adder between two
// requesters. It applies a per-requester credit limit and returns each result to its requester using a tag.
module fpadd_arbiter #(
  parameter int LATENCY = 3,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  input  logic [63:0] in0_a,
  input  logic [63:0] in0_b,
  input  logic        in1_valid,
  input  logic [63:0] in1_a,
  input  logic [63:0] in1_b,
  output logic        in0_ready,
  output logic        in1_ready,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  input  logic [63:0] add_sum,
  output logic        out0_valid,
  output logic        out1_valid,
  output logic [63:0] out0_sum,
  output logic [63:0] out1_sum,
  output logic        busy,
  output logic [15:0] issue_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  logic [3:0]       out_cnt0;
  logic [3:0]       out_cnt1;
  logic             last_grant;
  logic             elig0;
  logic             elig1;
  logic             xfer0;
  logic             xfer1;
  logic             xfer;
  logic [LATENCY:0] tag_valid;
  logic [LATENCY:0] tag_id;
  logic             ret_valid;
  logic             ret_id;

  assign elig0 = in0_valid && (out_cnt0 < MAX_CNT);
  assign elig1 = in1_valid && (out_cnt1 < MAX_CNT);

  // last_grant=1 means requester 1 won most recently, so requester 0 wins the next tie
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        in0_ready = last_grant;
        in1_ready = !last_grant;
      end else begin
        in0_ready = elig0;
        in1_ready = elig1;
      end
    end
  end

  assign xfer0 = in0_valid && in0_ready;
  assign xfer1 = in1_valid && in1_ready;
  assign xfer  = xfer0 || xfer1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      add_a       <= 64'd0;
      add_b       <= 64'd0;
      issue_count <= 16'd0;
    end else begin
      if (xfer0) begin
        last_grant <= 1'b0;
        add_a      <= in0_a;
        add_b      <= in0_b;
      end else if (xfer1) begin
        last_grant <= 1'b1;
        add_a      <= in1_a;
        add_b      <= in1_b;
      end
      issue_count <= issue_count + 16'(xfer);
    end
  end

  // Tag stage LATENCY lines up with add_sum carrying that operation's result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= xfer;
      tag_id[0]    <= xfer1;
      for (int i = 1; i <= LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign ret_valid = tag_valid[LATENCY];
  assign ret_id    = tag_id[LATENCY];
  assign busy      = |tag_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
      out0_sum   <= 64'd0;
      out1_sum   <= 64'd0;
    end else begin
      out0_valid <= ret_valid && !ret_id;
      out1_valid <= ret_valid && ret_id;
      if (ret_valid && !ret_id) out0_sum <= add_sum;
      if (ret_valid && ret_id)  out1_sum <= add_sum;
    end
  end

  // A credit is released by the edge that sees out_valid, so a full requester regains ready one cycle after its pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt0 <= 4'd0;
      out_cnt1 <= 4'd0;
    end else begin
      case ({xfer0, out0_valid})
        2'b10:   out_cnt0 <= out_cnt0 + 4'd1;
        2'b01:   out_cnt0 <= out_cnt0 - 4'd1;
        default: out_cnt0 <= out_cnt0;
      endcase
      case ({xfer1, out1_valid})
        2'b10:   out_cnt1 <= out_cnt1 + 4'd1;
        2'b01:   out_cnt1 <= out_cnt1 - 4'd1;
        default: out_cnt1 <= out_cnt1;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter: directed stimulus with a behavioural 3-stage adder.
// The monitor matches every result pulse against the queued expectations.
module tb_fpadd_arbiter;

  localparam int LATENCY = 3;
  localparam int MAX_OUT = 4;

  localparam logic [63:0] A90  = 64'h4056800000000000;
  localparam logic [63:0] S180 = 64'h4066800000000000;
  localparam logic [63:0] A50  = 64'h4049000000000000;
  localparam logic [63:0] A20  = 64'h4034000000000000;
  localparam logic [63:0] S70  = 64'h4051800000000000;

  logic        clk;
  logic        rst;
  logic        in0_valid, in1_valid;
  logic [63:0] in0_a, in0_b, in1_a, in1_b;
  logic        in0_ready, in1_ready;
  logic [63:0] add_a, add_b, add_sum;
  logic        out0_valid, out1_valid;
  logic [63:0] out0_sum, out1_sum;
  logic        busy;
  logic [15:0] issue_count;

  typedef struct {
    logic        id;
    logic [63:0] sum;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   check_count = 0;
  int   pass_count  = 0;
  int   cycle       = 0;
  logic [63:0] p1, p2;

  fpadd_arbiter #(.LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_a(in0_a), .in0_b(in0_b),
    .in1_valid(in1_valid), .in1_a(in1_a), .in1_b(in1_b),
    .in0_ready(in0_ready), .in1_ready(in1_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_sum(out0_sum), .out1_sum(out1_sum),
    .busy(busy), .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural shared adder: three register stages from add_a/add_b to add_sum
  always @(posedge clk) begin
    p1      <= $realtobits($bitstoreal(add_a) + $bitstoreal(add_b));
    p2      <= p1;
    add_sum <= p2;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Drive one cycle of valids, check the grant, and queue expectations for granted requesters
  task automatic applyStimulus(input logic v0, input logic v1, input logic exp_r0, input logic exp_r1);
    in0_valid = v0;
    in1_valid = v1;
    @(negedge clk);
    checkOutput("in0_ready", 64'(in0_ready), 64'(exp_r0));
    checkOutput("in1_ready", 64'(in1_ready), 64'(exp_r1));
    if (v0 && exp_r0) sb.push_back('{1'b0, S180, cycle + LATENCY + 2});
    if (v1 && exp_r1) sb.push_back('{1'b1, S70, cycle + LATENCY + 2});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pending_results", 64'(sb.size()), 64'd0);
  endtask

  task automatic doReset();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && (out0_valid || out1_valid)) begin
      if (sb.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_result out0_valid=%0b out1_valid=%0b required none (cycle %0d)",
                 out0_valid, out1_valid, cycle);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result_valids", 64'({out1_valid, out0_valid}), mon_e.id ? 64'd2 : 64'd1);
        checkOutput("result_sum", mon_e.id ? out1_sum : out0_sum, mon_e.sum);
        checkOutput("result_cycle", 64'(cycle), 64'(mon_e.due));
      end
    end
  end

  initial begin
    logic [0:10] credit_pat;
    rst = 1'b1;
    in0_a = A90; in0_b = A90;
    in1_a = A50; in1_b = A20;
    in0_valid = 1'b1;
    in1_valid = 1'b1;

    // Reset state, with both requesters asking
    @(negedge clk);
    checkOutput("rst_in0_ready", 64'(in0_ready), 64'd0);
    checkOutput("rst_in1_ready", 64'(in1_ready), 64'd0);
    checkOutput("rst_add_a", add_a, 64'd0);
    checkOutput("rst_add_b", add_b, 64'd0);
    checkOutput("rst_out0_sum", out0_sum, 64'd0);
    checkOutput("rst_out1_sum", out1_sum, 64'd0);
    checkOutput("rst_out_valids", 64'({out1_valid, out0_valid}), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_issue_count", 64'(issue_count), 64'd0);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single operation");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("single_busy", 64'(busy), 64'd1);
    checkOutput("single_add_a", add_a, A90);
    idle(8);
    checkOutput("single_out0_sum", out0_sum, S180);
    checkOutput("single_out1_sum", out1_sum, 64'd0);
    checkOutput("single_issue_count", 64'(issue_count), 64'd1);
    checkOutput("single_busy_idle", 64'(busy), 64'd0);

    $display("[TB] round-robin tie");
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1);
    checkOutput("tie_issue_count", 64'(issue_count), 64'd8);
    idle(8);
    checkOutput("tie_out0_sum", out0_sum, S180);
    checkOutput("tie_out1_sum", out1_sum, S70);

    $display("[TB] credit limit");
    doReset();
    credit_pat = 11'b11110011110;
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, i == 10, credit_pat[i], i == 10);
    idle(10);
    checkOutput("credit_issue_count", 64'(issue_count), 64'd9);
    checkOutput("credit_out1_sum", out1_sum, S70);

    $display("[TB] reset mid-flight");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_issue_count", 64'(issue_count), 64'd0);
    checkOutput("midrst_out_valids", 64'({out1_valid, out0_valid}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("midrst_fresh_count", 64'(issue_count), 64'd4);
    idle(10);

    $display("[TB] issue_count wrap");
    doReset();
    for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1);
    checkOutput("wrap_preload", 64'(issue_count), 64'hFFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("wrap_issue_count", 64'(issue_count), 64'd0);
    idle(8);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
